// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared binary32 types, class codes and constants for the FPU datapath
package fpu_pkg;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
    } float_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        SPEC = 2'd2
    } fclass_t;

    localparam int         EXP_BIAS = 127;
    localparam logic [7:0] EXP_MAX  = 8'hFF;

    // Denormals are flushed, so a zero exponent always classifies as ZERO.
    function automatic fclass_t fclass(input float_t f);
        if (f.e == 8'h00) return ZERO;
        if (f.e == EXP_MAX) return SPEC;
        return NORM;
    endfunction

endpackage

// File: rtl/finv.sv
// rtl/finv.sv - combinational binary32 reciprocal with truncated mantissa
module finv
    import fpu_pkg::*;
(
    input  float_t i_x,
    output float_t o_r
);

    logic [47:0] w_num;
    logic [47:0] w_den;
    logic [23:0] w_q;

    assign w_num = 48'h8000_0000_0000;
    assign w_den = {24'd0, 1'b1, i_x.m};
    // 2^47 / 1.m lies in (2^23, 2^24]; only m==0 reaches 2^24, which truncates to 0 here.
    assign w_q   = 24'(w_num / w_den);

    always_comb begin
        o_r.s = i_x.s;
        if (i_x.e >= 8'd254) begin
            o_r.e = 8'd0;
            o_r.m = 23'd0;
        end else begin
            o_r.e = 8'd253 - i_x.e + {7'd0, ~w_q[23]};
            o_r.m = w_q[22:0];
        end
    end

endmodule

// File: rtl/fmul_norm_round.sv
// rtl/fmul_norm_round.sv - mantissa multiply, normalise and round-to-nearest-even for normal operands
module fmul_norm_round
    import fpu_pkg::*;
(
    input  float_t i_a,
    input  float_t i_b,
    output float_t o_y,
    output logic   o_ovf,
    output logic   o_unf
);

    logic [47:0]       w_p;
    logic [22:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_lsb;
    logic              w_rnd;
    logic [23:0]       w_mr;
    logic signed [9:0] w_e;

    assign w_p = {1'b1, i_a.m} * {1'b1, i_b.m};

    always_comb begin
        if (w_p[47]) begin
            w_mant   = w_p[46:24];
            w_guard  = w_p[23];
            w_sticky = |w_p[22:0];
            w_lsb    = w_p[24];
        end else begin
            w_mant   = w_p[45:23];
            w_guard  = w_p[22];
            w_sticky = |w_p[21:0];
            w_lsb    = w_p[23];
        end
    end

    assign w_rnd = w_guard & (w_sticky | w_lsb);
    // A carry out of the rounded mantissa leaves w_mr[22:0] all zero, i.e. 1.0 at the next exponent.
    assign w_mr  = {1'b0, w_mant} + {23'd0, w_rnd};
    assign w_e   = 10'(i_a.e) + 10'(i_b.e) - 10'(EXP_BIAS) + 10'(w_p[47]) + 10'(w_mr[23]);

    assign o_ovf = (w_e >= 10'sd255);
    assign o_unf = (w_e <= 10'sd0);

    always_comb begin
        o_y.s = i_a.s ^ i_b.s;
        if (o_ovf) begin
            o_y.e = EXP_MAX;
            o_y.m = 23'd0;
        end else if (o_unf) begin
            o_y.e = 8'd0;
            o_y.m = 23'd0;
        end else begin
            o_y.e = w_e[7:0];
            o_y.m = w_mr[22:0];
        end
    end

endmodule

// File: rtl/fdiv_pipe.sv
// rtl/fdiv_pipe.sv - three-stage binary32 divider computing x1 * finv(x2) with valid/ready flow control
module fdiv_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        dz
);

    logic    r_s1_valid;
    float_t  r_s1_x1;
    float_t  r_s1_x2;
    fclass_t r_s1_c1;
    fclass_t r_s1_c2;

    logic    r_s2_valid;
    float_t  r_s2_x1;
    float_t  r_s2_r;
    fclass_t r_s2_c1;
    fclass_t r_s2_c2;
    logic    r_s2_sgn;

    logic        r_out_valid;
    logic [31:0] r_y;
    logic        r_dz;

    logic   w_stall;
    float_t w_inv;
    float_t w_mul_y;
    logic   w_ovf;
    logic   w_unf;
    float_t w_y;
    logic   w_dz;

    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign dz        = r_dz;

    finv u_finv (
        .i_x (r_s1_x2),
        .o_r (w_inv)
    );

    fmul_norm_round u_fmul (
        .i_a   (r_s2_x1),
        .i_b   (r_s2_r),
        .o_y   (w_mul_y),
        .o_ovf (w_ovf),
        .o_unf (w_unf)
    );

    // Special-case priority: divide-by-zero wins over Inf/NaN operands, which win over a zero dividend.
    always_comb begin
        w_dz = 1'b0;
        w_y  = '{s: r_s2_sgn, e: 8'd0, m: 23'd0};
        if (r_s2_c2 == ZERO) begin
            w_y.e = EXP_MAX;
            w_dz  = 1'b1;
        end else if (r_s2_c1 == SPEC || r_s2_c2 == SPEC) begin
            w_y.e = EXP_MAX;
        end else if (r_s2_c1 == ZERO) begin
            w_y.e = 8'd0;
        end else if (w_ovf) begin
            w_y.e = EXP_MAX;
        end else if (!w_unf) begin
            w_y = w_mul_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= 32'h0;
            r_dz        <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid;
            r_s1_x1     <= float_t'(x1);
            r_s1_x2     <= float_t'(x2);
            r_s1_c1     <= fclass(float_t'(x1));
            r_s1_c2     <= fclass(float_t'(x2));

            r_s2_valid  <= r_s1_valid;
            r_s2_x1     <= r_s1_x1;
            r_s2_r      <= w_inv;
            r_s2_c1     <= r_s1_c1;
            r_s2_c2     <= r_s1_c2;
            r_s2_sgn    <= r_s1_x1.s ^ r_s1_x2.s;

            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_y  <= w_y;
                r_dz <= w_dz;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_pipe.sv
// tb/tb_fdiv_pipe.sv - self-checking bench for fdiv_pipe against a real-arithmetic quotient model
module tb_fdiv_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        dz;

    always #5 clk = ~clk;

    fdiv_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .dz        (dz)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_out    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        if (b[30:23] == 8'd0) return 0.0;
        return (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    endfunction

    function automatic real ulp_of(input real v);
        int  k;
        real t;
        k = 0;
        t = v;
        while (t >= 2.0) begin t = t / 2.0; k++; end
        while (t < 1.0)  begin t = t * 2.0; k--; end
        return 2.0 ** real'(k - 23);
    endfunction

    function automatic logic [31:0] rnd_norm();
        return {1'($urandom), 8'($urandom_range(180, 70)), 23'($urandom)};
    endfunction

    // Expected result from the quotient of the decoded operands, with special cases by operand class.
    task automatic score(input op_t o, input logic [31:0] yo, input logic d);
        logic        s;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [31:0] inf_v;
        logic [31:0] zero_v;
        real         qv;
        real         err;
        s      = o.a[31] ^ o.b[31];
        ea     = o.a[30:23];
        eb     = o.b[30:23];
        inf_v  = {s, 8'hFF, 23'h0};
        zero_v = {s, 31'h0};
        if (eb == 8'd0) begin
            check("dz_flag", 32'(d), 32'd1);
            check("dz_y", yo, inf_v);
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            check("spec_dz", 32'(d), 32'd0);
            check("spec_y", yo, inf_v);
        end else if (ea == 8'd0) begin
            check("zero_dz", 32'(d), 32'd0);
            check("zero_y", yo, zero_v);
        end else begin
            qv = f2r(o.a) / f2r(o.b);
            check("norm_dz", 32'(d), 32'd0);
            if (qv >= 2.0 ** 128.0) begin
                check("ovf_y", yo, inf_v);
            end else if (qv < 2.0 ** (-126.0)) begin
                check("unf_y", yo, zero_v);
            end else begin
                err = f2r(yo) - qv;
                if (err < 0.0) err = -err;
                check("sign", 32'(yo[31]), 32'(s));
                check("ulp4", 32'(yo[30:23] != 8'd0 && yo[30:23] != 8'hFF && err <= 4.0 * ulp_of(qv)), 32'd1);
            end
        end
    endtask

    task automatic tick(output bit acc);
        op_t o;
        #1;
        acc = in_valid && in_ready && !rst;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("extra_output", 32'(out_valid), 32'd0);
            end else begin
                o = q.pop_front();
                n_out++;
                score(o, y, dz);
            end
        end
        if (acc) begin
            o.a = x1;
            o.b = x2;
            q.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] yo, output logic dzo, output int lat);
        bit acc;
        x1       = a;
        x2       = b;
        in_valid = 1'b1;
        tick(acc);
        check("accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            tick(acc);
            lat++;
        end
        yo  = y;
        dzo = dz;
    endtask

    initial begin
        bit          acc;
        int          lat;
        int          cyc;
        int          sent;
        int          base;
        int          diff;
        logic [31:0] yv;
        logic        dv;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x1        = 32'h0;
        x2        = 32'h0;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'h0);
        check("rst_dz", 32'(dz), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_one(32'h40C00000, 32'h40000000, yv, dv, lat);
        check("lat_6_2", 32'(lat), 32'd3);
        check("y_6_2", yv, 32'h40400000);
        check("dz_6_2", 32'(dv), 32'd0);

        run_one(32'h3F800000, 32'h40400000, yv, dv, lat);
        diff = int'(yv) - int'(32'h3EAAAAAB);
        check("y_1_3", 32'(diff >= -4 && diff <= 4), 32'd1);

        run_one(32'h3F800000, 32'h00000000, yv, dv, lat);
        check("y_1_0", yv, 32'h7F800000);
        check("dz_1_0", 32'(dv), 32'd1);

        run_one(32'h80000000, 32'h40400000, yv, dv, lat);
        check("y_m0_3", yv, 32'h80000000);
        check("dz_m0_3", 32'(dv), 32'd0);

        run_one(32'h7F000000, 32'h3E800000, yv, dv, lat);
        check("y_ovf", yv, 32'h7F800000);

        run_one(32'h00800000, 32'h4B000000, yv, dv, lat);
        check("y_unf", yv, 32'h00000000);

        run_one(32'h7F800000, 32'h40000000, yv, dv, lat);
        check("y_inf_2", yv, 32'h7F800000);
        check("dz_inf_2", 32'(dv), 32'd0);

        tick(acc);

        // 20 back-to-back operations with the consumer stalling in cycles 5..8.
        base = n_out;
        sent = 0;
        cyc  = 0;
        x1   = rnd_norm();
        x2   = rnd_norm();
        while (cyc < 80 && (sent < 20 || q.size() > 0)) begin
            out_ready = !(cyc >= 5 && cyc <= 8);
            in_valid  = (sent < 20);
            #1;
            if (cyc >= 5 && cyc <= 8) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                if (q.size() > 0) score(q[0], y, dz);
            end
            tick(acc);
            if (acc) begin
                sent++;
                x1 = rnd_norm();
                x2 = rnd_norm();
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'd20);
        check("stream_drained", 32'(q.size()), 32'd0);
        check("stream_count", 32'(n_out - base), 32'd20);

        // Random valid/ready activity.
        for (int i = 0; i < 150; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            if (in_valid) begin
                x1 = rnd_norm();
                x2 = rnd_norm();
            end
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            tick(acc);
            cyc++;
        end
        check("random_drained", 32'(q.size()), 32'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x1 = rnd_norm();
            x2 = rnd_norm();
            tick(acc);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick(acc);
        rst = 1'b0;
        q.delete();
        check("rst_flush_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            check("rst_no_ghost", 32'(out_valid), 32'd0);
        end

        run_one(32'h40800000, 32'h40000000, yv, dv, lat);
        check("lat_4_2", 32'(lat), 32'd3);
        check("y_4_2", yv, 32'h40000000);
        tick(acc);
        check("final_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fdiv_pipe.md
Name: fdiv_pipe

Overview:
- Pipelined single-precision divider, q = x1 / x2, computed as x1 * (1/x2).
- Consumes the combinational reciprocal unit (finv) directly: its input is fed from a pipeline register, and its output is captured and multiplied by x1.
- Sits in the FPU between operand dispatch and writeback.
- Uses a valid/ready handshake and accepts one operation per cycle when not stalled.

Parameters:
- none. Latency is fixed at 3 cycles and is not configurable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair is present.
- in_ready  out  1  block can accept an operand pair this cycle.
- x1  in  32  dividend, IEEE-754 binary32.
- x2  in  32  divisor, IEEE-754 binary32.
- out_valid  out  1  result is present.
- out_ready  in  1  consumer accepts the result.
- y  out  32  quotient, binary32.
- dz  out  1  divide-by-zero flag; qualified by out_valid.

Behaviour:
- Reset: synchronous, active-high, single clock clk. While rst=1 at a clock edge:
  - all stage valid bits clear to 0;
  - out_valid=0, y=32'h0, dz=0;
  - in_ready=1 in the cycle after reset.
- Reset asserted mid-operation discards every in-flight operation; none of them emerges afterwards.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is combinational, with no dependency on in_valid.
  - When stall=1, every stage register holds its value.
  - Bubbles are not compressed. This is a decided simplification.
- Accept: the operation is accepted when in_valid & in_ready at a clock edge.
- Latency: an accepted operation appears with out_valid=1 exactly 3 edges later if no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: 1 operation per cycle.
- Results leave in acceptance order.
- y and dz stay stable while out_valid & ~out_ready.
- S1 (edge 1) captures:
  - x1 and x2;
  - a class code: ZERO (exp==0, denormals flushed), SPEC (exp==255), or NORM.
- S2 (edge 2):
  - The finv instance is driven combinationally from the S1 x2 register.
  - Its 32-bit result r is registered together with x1 and both class codes.
- S3 (edge 3): mantissa multiply, normalise, round, then register y and dz.
  - Product: p = {1,m1} * {1,mr}, 48 bits.
  - Normalise: if p[47]=1, use mantissa p[46:24] and increment the exponent; otherwise use p[45:23].
  - Round: round-to-nearest-even on the discarded bits. A rounding carry renormalises the result and increments the exponent.
  - Exponent: e = e1 + er - 127 + norm_inc + round_inc, computed in 10-bit signed arithmetic.
  - Sign: s1 ^ s2 in all cases.
- Special cases, evaluated in priority order:
  1. x2 ZERO: y = {s, 8'hFF, 23'h0}, dz=1. This includes 0/0; NaN is not produced.
  2. x1 SPEC or x2 SPEC: y = {s, 8'hFF, 23'h0}, dz=0.
  3. x1 ZERO: y = {s, 31'h0}.
  4. e >= 255: overflow, y = {s, 8'hFF, 23'h0}.
  5. e <= 0: underflow, y = {s, 31'h0}; no denormal output.
- dz is 0 in every case except case 1.
- Accuracy: for normal operands and normal results, |y - IEEE(x1/x2)| <= 4 ulp. The finv error is included in this bound.

Decomposition:
- fpu_pkg holds:
  - typedef float_t: packed struct with fields s, e[7:0], m[22:0];
  - enum fclass_t: ZERO, NORM, SPEC;
  - constants EXP_BIAS=127, EXP_MAX=8'hFF;
  - function fclass(float_t) returning fclass_t.
- Sub-module fmul_norm_round: combinational. It takes the two float_t operands and returns {y, ovf, unf}. It is reusable by the standalone fmul.
- finv is instanced unchanged in S2.

Test Plan:
- 40C00000 / 40000000 (6/2): accept at edge N, out_valid at edge N+3 -> y=40400000, dz=0.
- 3F800000 / 40400000 (1/3): y within 4 ulp of 3EAAAAAB; then 3F800000 / 00000000 -> y=7F800000, dz=1. Then 80000000 / 40400000 -> y=80000000, dz=0.
- Back-to-back streaming with out_ready=0 for cycles 5-8:
  - in_ready=0 during 5-8;
  - y is held through the stall;
  - no operation is lost or duplicated;
  - order is preserved over 20 random normal pairs.
- 7F000000 / 3E800000 -> y=7F800000 (overflow). 00800000 / 4B000000 -> y=00000000 (underflow).
- Reset for 1 cycle with 3 operations in flight -> out_valid=0 from the next edge, none of the 3 appear later. The next operation 40800000 / 40000000 -> y=40000000 after 3 cycles.
- x1=7F800000 (SPEC) / 40000000 -> y=7F800000, dz=0.
